// File: rtl/pipe_fft_pkg.sv
// Shared constants and types for the pipeFFT stage controllers.
// Holds the default widths and the legal range for the delay-line length.
package pipe_fft_pkg;

    localparam int DW_DEF     = 68;
    localparam int AW_DEF     = 4;
    localparam int RD_LAT_DEF = 2;
    localparam int DLY_DEF    = 15;
    localparam int DLY_MIN    = 1;

    typedef logic [DW_DEF-1:0] sample_t;

    // Longest delay a 2**aw deep memory can hold without read/write collision
    function automatic int dly_max(input int aw);
        return (1 << aw) - 1;
    endfunction

endpackage

// File: rtl/pipe_fft_vld_pipe.sv
// Valid-bit shift register with synchronous flush.
// Shared by pipeFFT stages to align a valid flag with a fixed-latency datapath.
module pipe_fft_vld_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    if (DEPTH < 2) begin : g_bad_depth
        $error("pipe_fft_vld_pipe: DEPTH must be at least 2");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pipe_fft_dly_ctrl.sv
// Delay-memory controller for one pipeFFT stage: writes valid samples into the
// external two-port RAM and reads back the sample from DLY valid inputs earlier.
module pipe_fft_dly_ctrl
    import pipe_fft_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int DLY    = DLY_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          nGrst,
    input  logic          sync,
    input  logic          in_vld,
    input  logic [DW-1:0] in_d,
    output logic [DW-1:0] mem_wD,
    output logic [AW-1:0] mem_wAddr,
    output logic          mem_wEn,
    output logic [AW-1:0] mem_rAddr,
    input  logic [DW-1:0] mem_rD,
    output logic          out_vld,
    output logic [DW-1:0] out_d,
    output logic          primed
);

    localparam int            CW    = $clog2(DLY + 1);
    localparam logic [AW-1:0] DLY_A = AW'(DLY);

    if (DLY < DLY_MIN || DLY > dly_max(AW) || RD_LAT < 1) begin : g_bad_param
        $error("pipe_fft_dly_ctrl: DLY must be 1..2**AW-1 and RD_LAT at least 1");
    end

    logic [AW-1:0] wptr;
    logic [CW-1:0] prime_cnt;
    logic          primed_next;
    logic          tail;

    assign primed_next = (prime_cnt == CW'(DLY));

    // Pointers advance only on valid samples, so the delay is measured in samples
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            wptr      <= '0;
            prime_cnt <= '0;
            primed    <= 1'b0;
            mem_wEn   <= 1'b0;
            mem_wAddr <= '0;
            mem_wD    <= '0;
            mem_rAddr <= '0;
        end else if (sync) begin
            wptr      <= '0;
            prime_cnt <= '0;
            primed    <= 1'b0;
            mem_wEn   <= 1'b0;
            mem_wAddr <= '0;
            mem_wD    <= '0;
            mem_rAddr <= '0;
        end else begin
            mem_wEn <= in_vld;
            if (in_vld) begin
                mem_wAddr <= wptr;
                mem_wD    <= in_d;
                mem_rAddr <= wptr - DLY_A;
                wptr      <= wptr + AW'(1);
                if (!primed_next) begin
                    prime_cnt <= prime_cnt + CW'(1);
                end
                if (prime_cnt == CW'(DLY - 1)) begin
                    primed <= 1'b1;
                end
            end
        end
    end

    // One cycle for the address register plus the memory's own read latency
    pipe_fft_vld_pipe #(
        .DEPTH (1 + RD_LAT)
    ) u_vld_pipe (
        .clk   (clk),
        .rst_n (nGrst),
        .flush (sync),
        .din   (in_vld & primed_next),
        .dout  (tail)
    );

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            out_vld <= 1'b0;
            out_d   <= '0;
        end else if (sync) begin
            out_vld <= 1'b0;
            out_d   <= '0;
        end else begin
            out_vld <= tail;
            if (tail) begin
                out_d <= mem_rD;
            end
        end
    end

endmodule
